// File: rtl/conv_mac_seq_if.sv
// conv_mac_seq_if: transaction and result handshake bundle for the convolution MAC
interface conv_mac_seq_if #(
  parameter int N = 8,
  parameter int FIL = 3,
  parameter int ACC_W = 2*N+4
);
  localparam int K = FIL*FIL;
  logic in_valid;
  logic in_ready;
  logic [K*N-1:0] I_in;
  logic [K*N-1:0] F_in;
  logic [ACC_W-1:0] bias;
  logic [1:0] mode;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] c;
  logic [ACC_W-1:0] acc_out;
  logic busy;
  modport master (
    output in_valid, I_in, F_in, bias, mode, out_ready,
    input in_ready, out_valid, c, acc_out, busy
  );
  modport slave (
    input in_valid, I_in, F_in, bias, mode, out_ready,
    output in_ready, out_valid, c, acc_out, busy
  );
endinterface

// File: rtl/conv_mac_seq.sv
// conv_mac_seq: sequential FILxFIL convolution MAC, LANES taps per beat, wrap/saturate/ReLU output
module conv_mac_seq #(
  parameter int N = 8,
  parameter int FIL = 3,
  parameter int LANES = 1,
  parameter int ACC_W = 2*N+4,
  parameter int SIGNED = 0,
  parameter int SHIFT = 0
) (
  input logic clk,
  input logic rst_n,
  conv_mac_seq_if.slave bus
);
  localparam int K = FIL*FIL;
  localparam int TW = $clog2(K+1);
  localparam bit SG = SIGNED != 0;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] tap;
  logic [K*N-1:0] img, fil;
  logic [1:0] md;
  logic [ACC_W-1:0] acc, acc_nxt, beat_sum, s, acc_q;
  logic signed [ACC_W-1:0] ss;
  logic [N-1:0] c_q, c_nxt, hi, lo, sat;
  logic last, neg, ovf, unf;
  function automatic logic [ACC_W-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] ps;
    logic [2*N-1:0] pu;
    logic signed [ACC_W-1:0] es;
    logic [ACC_W-1:0] eu;
    ps = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
    pu = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    es = ACC_W'(ps);
    eu = ACC_W'(pu);
    return SG ? es : eu;
  endfunction
  // Sum of this beat's lane products; lanes beyond the last tap add nothing.
  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++)
      if (int'(tap) + l < K) beat_sum = beat_sum + prod(img[(int'(tap)+l)*N +: N], fil[(int'(tap)+l)*N +: N]);
  end
  assign acc_nxt = acc + beat_sum;
  assign last = int'(tap) + LANES >= K;
  // Output stage on the final sum: shift, then wrap, clamp or ReLU-clamp.
  always_comb begin
    ss = $signed(acc_nxt) >>> SHIFT;
    s = SG ? ss : acc_nxt >> SHIFT;
    neg = SG & s[ACC_W-1];
    ovf = SG ? (!neg && |s[ACC_W-1:N-1]) : |s[ACC_W-1:N];
    unf = neg && !(&s[ACC_W-1:N-1]);
    hi = SG ? {1'b0, {(N-1){1'b1}}} : {N{1'b1}};
    lo = SG ? {1'b1, {(N-1){1'b0}}} : {N{1'b0}};
    sat = ovf ? hi : unf ? lo : s[N-1:0];
    c_nxt = md == 2'b00 ? s[N-1:0] : (md == 2'b10 && neg) ? {N{1'b0}} : sat;
  end
  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // Next state: accept in IDLE, finish on the last beat, release on out_ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = bus.in_valid ? ACC : IDLE;
      ACC: state_nxt = last ? DONE : ACC;
      DONE: state_nxt = bus.out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // Datapath: capture the transaction, accumulate beats, register the result.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tap <= '0;
      img <= '0;
      fil <= '0;
      md <= '0;
      acc <= '0;
      acc_q <= '0;
      c_q <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      img <= bus.I_in;
      fil <= bus.F_in;
      md <= bus.mode;
      acc <= bus.bias;
      tap <= '0;
    end else if (state == ACC) begin
      acc <= acc_nxt;
      if (last) begin
        acc_q <= acc_nxt;
        c_q <= c_nxt;
      end else tap <= tap + TW'(LANES);
    end
  assign bus.in_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.c = c_q;
  assign bus.acc_out = acc_q;
endmodule

// File: tb/tb_conv_mac_seq.sv
// tb_conv_mac_seq: scoreboard bench running unsigned, signed and 4-lane MACs on shared stimulus
module tb_conv_mac_seq;
  localparam int N = 8;
  localparam int FIL = 3;
  localparam int K = FIL*FIL;
  localparam int ACC_W = 2*N+4;
  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [N-1:0] c;
  } res_t;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic out_ready = 1;
  logic [K*N-1:0] img = '0;
  logic [K*N-1:0] fil = '0;
  logic [ACC_W-1:0] bias = '0;
  logic [1:0] mode = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  res_t q0[$], q1[$], q2[$];
  res_t last[3];
  logic ov[3], ov_d[3];
  logic [ACC_W-1:0] ao[3];
  logic [N-1:0] co[3];
  logic rdy;
  conv_mac_seq_if #(.N(N), .FIL(FIL), .ACC_W(ACC_W)) if0 ();
  conv_mac_seq_if #(.N(N), .FIL(FIL), .ACC_W(ACC_W)) if1 ();
  conv_mac_seq_if #(.N(N), .FIL(FIL), .ACC_W(ACC_W)) if2 ();
  conv_mac_seq #(.N(N), .FIL(FIL), .LANES(1), .ACC_W(ACC_W), .SIGNED(0), .SHIFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  conv_mac_seq #(.N(N), .FIL(FIL), .LANES(1), .ACC_W(ACC_W), .SIGNED(1), .SHIFT(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  conv_mac_seq #(.N(N), .FIL(FIL), .LANES(4), .ACC_W(ACC_W), .SIGNED(0), .SHIFT(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  assign if0.in_valid = in_valid;
  assign if0.out_ready = out_ready;
  assign if0.I_in = img;
  assign if0.F_in = fil;
  assign if0.bias = bias;
  assign if0.mode = mode;
  assign if1.in_valid = in_valid;
  assign if1.out_ready = out_ready;
  assign if1.I_in = img;
  assign if1.F_in = fil;
  assign if1.bias = bias;
  assign if1.mode = mode;
  assign if2.in_valid = in_valid;
  assign if2.out_ready = out_ready;
  assign if2.I_in = img;
  assign if2.F_in = fil;
  assign if2.bias = bias;
  assign if2.mode = mode;
  assign ov[0] = if0.out_valid;
  assign ov[1] = if1.out_valid;
  assign ov[2] = if2.out_valid;
  assign ao[0] = if0.acc_out;
  assign ao[1] = if1.acc_out;
  assign ao[2] = if2.acc_out;
  assign co[0] = if0.c;
  assign co[1] = if1.c;
  assign co[2] = if2.c;
  assign rdy = if0.in_ready & if1.in_ready & if2.in_ready;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic res_t model(input logic [K*N-1:0] i, input logic [K*N-1:0] f,
                                 input logic [ACC_W-1:0] b, input logic [1:0] m, input bit sg);
    res_t r;
    longint sum, v, hi, lo, cl;
    logic [N-1:0] a, w;
    sum = longint'(b);
    for (int t = 0; t < K; t++) begin
      a = i[t*N +: N];
      w = f[t*N +: N];
      if (sg) sum += longint'($signed(a)) * longint'($signed(w));
      else sum += longint'(a) * longint'(w);
    end
    r.acc = sum[ACC_W-1:0];
    v = longint'(r.acc);
    if (sg && r.acc[ACC_W-1]) v -= longint'(1) << ACC_W;
    hi = sg ? 127 : 255;
    lo = sg ? -128 : 0;
    cl = v > hi ? hi : v < lo ? lo : v;
    if (m == 2'b00) r.c = v[N-1:0];
    else if (m == 2'b10 && v < 0) r.c = '0;
    else r.c = cl[N-1:0];
    return r;
  endfunction
  function automatic logic [K*N-1:0] rnd_win();
    logic [K*N-1:0] r;
    for (int t = 0; t < K; t++) r[t*N +: N] = N'($urandom);
    return r;
  endfunction
  function automatic res_t pop(input int d, output bit ok);
    res_t r;
    r = '0;
    ok = 1;
    case (d)
      0: if (q0.size() > 0) r = q0.pop_front(); else ok = 0;
      1: if (q1.size() > 0) r = q1.pop_front(); else ok = 0;
      default: if (q2.size() > 0) r = q2.pop_front(); else ok = 0;
    endcase
    return r;
  endfunction
  // Result monitor: latency on out_valid rise, scoreboard compare on each handshake.
  always @(negedge clk) begin
    res_t e;
    bit ok;
    for (int d = 0; d < 3; d++) begin
      if (ov[d] && !ov_d[d]) check($sformatf("lat%0d", d), cyc - acc_cyc, d == 2 ? 3 : 9);
      if (ov[d] && out_ready) begin
        e = pop(d, ok);
        if (!ok) check($sformatf("spurious%0d", d), 1, 0);
        else begin
          check($sformatf("acc%0d", d), ao[d], e.acc);
          check($sformatf("c%0d", d), co[d], e.c);
        end
        last[d] = {ao[d], co[d]};
      end
      ov_d[d] = ov[d];
    end
  end
  task automatic push_exp(input logic [K*N-1:0] i, input logic [K*N-1:0] f,
                          input logic [ACC_W-1:0] b, input logic [1:0] m);
    q0.push_back(model(i, f, b, m, 0));
    q1.push_back(model(i, f, b, m, 1));
    q2.push_back(model(i, f, b, m, 0));
  endtask
  task automatic send(input logic [K*N-1:0] i, input logic [K*N-1:0] f,
                      input logic [ACC_W-1:0] b, input logic [1:0] m);
    int n;
    n = 0;
    while (!rdy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 100) check("ready_timeout", 0, 1);
    img = i;
    fil = f;
    bias = b;
    mode = m;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    acc_cyc = cyc;
    push_exp(i, f, b, m);
    img = rnd_win();
    fil = rnd_win();
    bias = ACC_W'($urandom);
    mode = 2'($urandom);
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 100) check("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [K*N-1:0] ni, nf;
    int n;
    #1;
    check("rst_in_ready", if0.in_ready, 1);
    check("rst_out_valid", if0.out_valid, 0);
    check("rst_busy", if0.busy, 0);
    check("rst_c", if0.c, 0);
    check("rst_acc", if0.acc_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    send({K{8'd1}}, {K{8'd2}}, '0, 2'b00);
    wait_done();
    check("t1_acc", last[0].acc, 18);
    check("t1_c", last[0].c, 18);
    send({K{8'd255}}, {K{8'd255}}, '0, 2'b00);
    wait_done();
    check("t2_acc", last[0].acc, 585225);
    check("t2_c_wrap", last[0].c, 8'h09);
    send({K{8'hFF}}, {K{8'd5}}, '0, 2'b01);
    wait_done();
    check("t3_acc", last[1].acc, 20'hFFFD3);
    check("t3_c_sat", last[1].c, 8'hD3);
    send({K{8'hFF}}, {K{8'd5}}, '0, 2'b10);
    wait_done();
    check("t3_c_relu", last[1].c, 8'h00);
    for (int r = 0; r < 10; r++) begin
      send(rnd_win(), rnd_win(), r < 5 ? ACC_W'(0) : ACC_W'($urandom), 2'(r));
      wait_done();
    end
    out_ready = 0;
    send({K{8'd255}}, {K{8'd255}}, '0, 2'b01);
    n = 0;
    while (!if0.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("hold_timeout", 0, 1);
    @(posedge clk);
    #1;
    ni = rnd_win();
    nf = rnd_win();
    img = ni;
    fil = nf;
    bias = '0;
    mode = 2'b01;
    in_valid = 1;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("hold_c", if0.c, 8'hFF);
      check("hold_acc", if0.acc_out, 585225);
      check("hold_in_ready", rdy, 0);
      check("hold_out_valid", if0.out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    @(posedge clk);
    #1;
    check("hs_in_ready", rdy, 1);
    @(posedge clk);
    #1;
    check("next_busy", if0.busy, 1);
    in_valid = 0;
    acc_cyc = cyc;
    push_exp(ni, nf, '0, 2'b01);
    wait_done();
    send({K{8'd3}}, {K{8'd7}}, '0, 2'b00);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_out_valid", if0.out_valid, 0);
    check("mid_rst_busy", if0.busy, 0);
    check("mid_rst_in_ready", if0.in_ready, 1);
    check("mid_rst_c", if0.c, 0);
    q0.delete();
    q1.delete();
    q2.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    send({K{8'd1}}, {K{8'd2}}, '0, 2'b00);
    wait_done();
    check("post_rst_c", last[0].c, 18);
    check("post_rst_acc", last[0].acc, 18);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
